// File: rtl/sipo_rx.sv
// -----------------------------------------------------------------------------
// sipo_rx -- serial-in/parallel-out word receiver.
//
// Receive end of the shift-register serial link. While `frame` is high, one
// bit of `sdi` is sampled on every clock edge that has `sdi_en` set. Each
// group of WIDTH bits forms a word. Completed words are handed downstream
// through a one-entry valid/ready holding register. Back-to-back words can
// stream within a single frame.
//
// Parameters
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: first bit received lands in dout[WIDTH-1]
//              0: first bit received lands in dout[0]
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   sdi         serial data in
//   sdi_en      bit strobe (sampled only while frame=1)
//   frame       word-framing envelope
//   dout        last completed word; stable while dout_valid=1
//   dout_valid  holding register full
//   dout_ready  downstream accepts dout when dout_valid=1
//   busy        receiver is inside a frame (SHIFT state)
//   overrun     1-cycle pulse: word dropped because holding register was full
//   frame_err   1-cycle pulse: frame ended with a partial word
// -----------------------------------------------------------------------------
module sipo_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sdi,
    input  logic             sdi_en,
    input  logic             frame,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             dout_valid_nxt;
    logic             overrun_nxt;
    logic             frame_err_nxt;

    logic [WIDTH-1:0] sr_shifted;
    logic             word_done;

    // Shift value including the bit presented on this edge.
    assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], sdi} : {sdi, sr[WIDTH-1:1]};

    assign busy = (state == SHIFT);

    // NOTE: every signal assigned here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sr_nxt         = sr;
        dout_nxt       = dout;
        dout_valid_nxt = dout_valid;
        overrun_nxt    = 1'b0;
        frame_err_nxt  = 1'b0;
        word_done      = 1'b0;

        unique case (state)
            IDLE: begin
                // WIDTH >= 2, so the first bit can never complete a word.
                if (frame && sdi_en) begin
                    sr_nxt    = sr_shifted;
                    cnt_nxt   = CW'(1);
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                // Falling frame takes priority over a strobe on the same edge.
                if (!frame) begin
                    frame_err_nxt = (cnt != '0);
                    cnt_nxt       = '0;
                    state_nxt     = IDLE;
                end else if (sdi_en) begin
                    sr_nxt = sr_shifted;
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        word_done = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase

        // Holding register: a pop on the same edge frees the slot for the
        // arriving word, so a simultaneous pop and load keeps dout_valid high.
        if (word_done) begin
            if (!dout_valid || dout_ready) begin
                dout_nxt       = sr_shifted;
                dout_valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid_nxt = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sr         <= sr_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            overrun    <= overrun_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// -----------------------------------------------------------------------------
// tb_sipo_rx -- directed self-checking bench for sipo_rx (WIDTH=8).
//
// Two instances share the stimulus: u_msb (MSB_FIRST=1) and u_lsb
// (MSB_FIRST=0). Inputs are driven on the falling clock edge. Outputs are
// checked on the falling edge that follows the rising edge of interest.
// -----------------------------------------------------------------------------
module tb_sipo_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sdi = 1'b0;
    logic         sdi_en = 1'b0;
    logic         frame = 1'b0;
    logic         dout_ready = 1'b0;

    logic [W-1:0] dout_m, dout_l;
    logic         valid_m, valid_l;
    logic         busy_m, busy_l;
    logic         ovr_m, ovr_l;
    logic         ferr_m, ferr_l;

    int n_vec = 0;
    int n_err = 0;

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .sdi(sdi), .sdi_en(sdi_en), .frame(frame),
        .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
        .busy(busy_m), .overrun(ovr_m), .frame_err(ferr_m)
    );

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .sdi(sdi), .sdi_en(sdi_en), .frame(frame),
        .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
        .busy(busy_l), .overrun(ovr_l), .frame_err(ferr_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; frame = 1'b0; sdi_en = 1'b0; sdi = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives the 8 bits of w, first bit = w[7], on consecutive cycles.
    // ready_last raises dout_ready together with the final bit.
    // Returns just after the final bit is driven, before its capture edge.
    task automatic send_word(input logic [W-1:0] w, input bit ready_last);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            frame = 1'b1; sdi_en = 1'b1; sdi = w[W-1-i];
            if (i == W - 1 && ready_last) dout_ready = 1'b1;
        end
    endtask

    initial begin
        logic [W-1:0] w;

        // ---------------- reset state ----------------
        do_reset();
        check("rst_dout", dout_m, 8'h00);
        check("rst_valid", {7'd0, valid_m}, 8'h00);
        check("rst_busy", {7'd0, busy_m}, 8'h00);
        check("rst_overrun", {7'd0, ovr_m}, 8'h00);
        check("rst_frame_err", {7'd0, ferr_m}, 8'h00);

        // ---------------- MSB-first 8'hA5 ----------------
        w = 8'hA5;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("a5_busy", {7'd0, busy_m}, 8'h01);
                check("a5_valid_early", {7'd0, valid_m}, 8'h00);
            end
            frame = 1'b1; sdi_en = 1'b1; sdi = w[W-1-i];
        end
        @(negedge clk);
        sdi_en = 1'b0;
        check("a5_dout", dout_m, 8'hA5);
        check("a5_valid", {7'd0, valid_m}, 8'h01);
        check("a5_lsb_dout", dout_l, 8'hA5);

        // ---------------- LSB-first: bits 1,1,0,0,0,0,0,0 ----------------
        do_reset();
        send_word(8'hC0, 1'b0);
        @(negedge clk);
        sdi_en = 1'b0;
        check("lsb_dout", dout_l, 8'h03);
        check("lsb_valid", {7'd0, valid_l}, 8'h01);
        check("lsb_msb_dout", dout_m, 8'hC0);

        // ---------------- back-pressure: 3C then C3, no pop ----------------
        do_reset();
        send_word(8'h3C, 1'b0);
        send_word(8'hC3, 1'b0);
        @(negedge clk);
        sdi_en = 1'b0;
        check("bp_overrun", {7'd0, ovr_m}, 8'h01);
        check("bp_dout", dout_m, 8'h3C);
        check("bp_valid", {7'd0, valid_m}, 8'h01);
        frame = 1'b0;
        @(negedge clk);
        check("bp_overrun_pulse", {7'd0, ovr_m}, 8'h00);
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        check("bp_pop_valid", {7'd0, valid_m}, 8'h00);
        check("bp_pop_dout", dout_m, 8'h3C);
        check("bp_silent_end", {7'd0, ferr_m}, 8'h00);

        // ---------------- simultaneous pop and load ----------------
        do_reset();
        send_word(8'h11, 1'b0);
        @(negedge clk);
        sdi_en = 1'b0;
        check("pl_first", dout_m, 8'h11);
        send_word(8'h22, 1'b1);
        @(negedge clk);
        sdi_en = 1'b0; dout_ready = 1'b0;
        check("pl_dout", dout_m, 8'h22);
        check("pl_valid", {7'd0, valid_m}, 8'h01);
        check("pl_overrun", {7'd0, ovr_m}, 8'h00);

        // ---------------- frame abort ----------------
        frame = 1'b0;                         // cnt=0: silent end of frame
        @(negedge clk);
        check("fa_silent", {7'd0, ferr_m}, 8'h00);
        check("fa_idle", {7'd0, busy_m}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            frame = 1'b1; sdi_en = 1'b1; sdi = i[0];
        end
        @(negedge clk);
        frame = 1'b0; sdi = 1'b1;             // strobe held high: frame=0 wins
        @(negedge clk);
        check("fa_frame_err", {7'd0, ferr_m}, 8'h01);
        check("fa_valid_kept", {7'd0, valid_m}, 8'h01);
        check("fa_dout_kept", dout_m, 8'h22);
        check("fa_busy", {7'd0, busy_m}, 8'h00);
        @(negedge clk);                        // strobe with frame=0 ignored
        sdi_en = 1'b0;
        check("fa_pulse", {7'd0, ferr_m}, 8'h00);
        check("fa_no_capture", {7'd0, busy_m}, 8'h00);
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        check("fa_pop", {7'd0, valid_m}, 8'h00);
        send_word(8'h5A, 1'b0);
        @(negedge clk);
        sdi_en = 1'b0;
        check("fa_next_dout", dout_m, 8'h5A);
        check("fa_next_valid", {7'd0, valid_m}, 8'h01);

        // ---------------- async reset mid-word, then gapped strobes ----------
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            frame = 1'b1; sdi_en = 1'b1; sdi = 1'b1;
        end
        @(negedge clk);
        sdi_en = 1'b0;
        check("ar_busy_before", {7'd0, busy_m}, 8'h01);
        #2 rst = 1'b0; frame = 1'b0;
        #1;
        check("ar_dout", dout_m, 8'h00);
        check("ar_valid", {7'd0, valid_m}, 8'h00);
        check("ar_busy", {7'd0, busy_m}, 8'h00);
        check("ar_overrun", {7'd0, ovr_m}, 8'h00);
        check("ar_frame_err", {7'd0, ferr_m}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ar_no_frame_err", {7'd0, ferr_m}, 8'h00);
        w = 8'h96;
        for (int i = 0; i < W; i++) begin
            repeat ($urandom_range(0, 4)) begin
                @(negedge clk);
                frame = 1'b1; sdi_en = 1'b0; sdi = ~sdi;
            end
            @(negedge clk);
            frame = 1'b1; sdi_en = 1'b1; sdi = w[W-1-i];
        end
        @(negedge clk);
        sdi_en = 1'b0;
        check("gap_dout", dout_m, 8'h96);
        check("gap_valid", {7'd0, valid_m}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- Serial-in/parallel-out word receiver: the receive end of the team's 8-bit shift-register serial link.
- Samples one bit per sdi_en strobe while frame is high and assembles WIDTH-bit words.
- Hands each completed word to downstream logic through a one-entry valid/ready holding register.
- Flags aborted frames and words dropped under back-pressure.

Parameters:
- WIDTH, 8, word length in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- sdi  input  1  serial data in.
- sdi_en  input  1  bit strobe; sdi is sampled on any clk edge where sdi_en=1 and frame=1.
- frame  input  1  word-framing envelope; high for the duration of one or more back-to-back words.
- dout  output  WIDTH  completed word; stable while dout_valid=1.
- dout_valid  output  1  holding register full.
- dout_ready  input  1  downstream accepts dout when dout_valid=1 and dout_ready=1.
- busy  output  1  high in SHIFT state.
- overrun  output  1  one-cycle pulse: a word completed while the holding register was full and not being popped.
- frame_err  output  1  one-cycle pulse: frame dropped with a partial word.

Behaviour:
- Reset (rst=0, any time, asynchronous), all outputs and state cleared:
  - state=IDLE, bit counter=0, shift register=0.
  - dout=0, dout_valid=0, busy=0, overrun=0, frame_err=0.
- Reset mid-word: the partial word is discarded and no frame_err is generated.
- Bit capture:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sdi}.
  - MSB_FIRST=0: sr <= {sdi, sr[WIDTH-1:1]}.
- Bit counter: width $clog2(WIDTH). Increments on each captured bit and wraps from WIDTH-1 to 0.
- Counter wrap means word complete. The completed word is the shift value including the bit captured on that edge.
- IDLE:
  - frame=1 and sdi_en=1: capture bit, cnt=1, go to SHIFT.
  - frame=1 and sdi_en=0: stay in IDLE.
  - sdi_en while frame=0: ignored.
- SHIFT:
  - frame=1 and sdi_en=1: capture bit.
  - On word complete: stay in SHIFT with cnt=0. Consecutive words stream within one frame.
  - frame=1 and sdi_en=0: hold all state (gaps of any length are legal).
  - frame=0 with cnt!=0: frame_err=1 for one cycle, cnt=0, sr unchanged, go to IDLE.
  - frame=0 with cnt=0: go to IDLE silently.
- Holding register:
  - On word complete with dout_valid=0, or dout_valid=1 and dout_ready=1 in the same cycle: dout <= word, dout_valid=1 on the next cycle. Latency is one clk after the edge that captures the last bit.
  - On word complete with dout_valid=1 and dout_ready=0: word dropped, dout unchanged, overrun=1 for one cycle.
  - Pop (dout_valid=1, dout_ready=1) with no word completing: dout_valid=0 next cycle; dout keeps its last value.
  - dout_ready while dout_valid=0: no effect.
- A bit on the same edge frame falls is not captured. frame=0 wins over sdi_en.
- overrun and frame_err are registered pulses and never assert together: a word can only complete while frame=1, and frame_err only fires when frame=0.
- Sustained throughput: one word per WIDTH strobes, provided downstream pops at least once per word.

Test Plan:
- MSB_FIRST=1, WIDTH=8: frame=1, strobe bits 1,0,1,0,0,1,0,1 on consecutive cycles -> dout=8'hA5, dout_valid=1 exactly one cycle after the 8th strobe; busy=1 during bits 1-7.
- MSB_FIRST=0: same bit sequence -> dout=8'hA5 reversed = 8'hA5 is a palindrome, so instead send 1,1,0,0,0,0,0,0 -> dout=8'h03.
- Back-pressure: dout_ready=0, stream 8'h3C then 8'hC3 in one frame -> dout stays 8'h3C, overrun pulses one cycle after the 16th strobe; then raise dout_ready -> dout_valid drops.
- Simultaneous pop and load: dout_valid=1 holding 8'h11, dout_ready=1 on the edge the next word 8'h22 completes -> dout=8'h22, dout_valid stays 1, overrun=0.
- Frame abort: 3 bits, then frame=0 -> frame_err pulses once, dout_valid unchanged. Next frame of 8 bits 8'h5A -> dout=8'h5A, with no stale bits.
- Async reset and strobe gaps: rst low mid-word (cnt=5) between clk edges -> all outputs 0 immediately, no frame_err. After release, 8 bits with random 0-4 cycle sdi_en gaps -> correct word.
